// File: rtl/dfz_window_pkg.sv
// Shared sizing constants and index helpers for the line-window generator.
package dfz_window_pkg;

    localparam int KER_SIZE_DEF    = 3;
    localparam int BITWIDTH_DEF    = 8;
    localparam int STRIDE_DEF      = 8;
    localparam int NFMAPS_DEF      = 3;
    localparam int INPUT_X_DIM_DEF = 28;
    localparam int AW_DEF          = 5;

    localparam int PIX_W = NFMAPS_DEF * BITWIDTH_DEF;
    localparam int COL_W = KER_SIZE_DEF * PIX_W;

    // Physical SRAM row holding age slot k when row w is being written.
    // w+1+k never reaches 2*(ker+1), so one conditional subtract is a full modulo.
    function automatic int row_rotate(input int w, input int k, input int ker);
        int idx;
        idx = w + 1 + k;
        if (idx >= ker + 1) begin
            idx = idx - (ker + 1);
        end
        return idx;
    endfunction

    function automatic int windows_per_row(input int x_dim, input int ker, input int stride);
        return (x_dim - ker) / stride + 1;
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// KER_SIZE x KER_SIZE pixel window that shifts left by one column per accepted column.
module window_shift_reg
    import dfz_window_pkg::*;
#(
    parameter int KER_SIZE = KER_SIZE_DEF,
    parameter int PIX_W    = dfz_window_pkg::PIX_W,
    parameter int COL_W    = dfz_window_pkg::COL_W
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clr_i,
    input  logic                      shift_i,
    input  logic [COL_W-1:0]          col_i,
    output logic [KER_SIZE*COL_W-1:0] win_next_o
);

    localparam int WIN_W = KER_SIZE * COL_W;

    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_d;

    // Layout is [row][col][pixel]; row r of the incoming column lands in col KER_SIZE-1.
    always_comb begin
        win_d = win_q;
        if (shift_i) begin
            for (int r = 0; r < KER_SIZE; r++) begin
                for (int c = 0; c < KER_SIZE; c++) begin
                    if (c < KER_SIZE - 1) begin
                        win_d[(r*KER_SIZE+c)*PIX_W +: PIX_W] = win_q[(r*KER_SIZE+c+1)*PIX_W +: PIX_W];
                    end else begin
                        win_d[(r*KER_SIZE+c)*PIX_W +: PIX_W] = col_i[r*PIX_W +: PIX_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_q <= '0;
        end else if (clr_i) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win_next_o = win_d;

endmodule

// File: rtl/line_window_gen.sv
// Sliding-window generator: rotates line-buffer rows into age order and emits one window per STRIDE columns.
module line_window_gen
    import dfz_window_pkg::*;
#(
    parameter int KER_SIZE    = KER_SIZE_DEF,
    parameter int BITWIDTH    = BITWIDTH_DEF,
    parameter int STRIDE      = STRIDE_DEF,
    parameter int NFMAPS      = NFMAPS_DEF,
    parameter int INPUT_X_DIM = INPUT_X_DIM_DEF,
    parameter int AW          = AW_DEF
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic                                       flush,
    input  logic                                       rd_valid,
    input  logic [AW-1:0]                              rd_addr,
    input  logic [KER_SIZE:0]                          write_en,
    input  logic [(KER_SIZE+1)*NFMAPS*BITWIDTH-1:0]    rd_data,
    output logic                                       win_valid,
    output logic [KER_SIZE*KER_SIZE*NFMAPS*BITWIDTH-1:0] win_data,
    output logic [AW-1:0]                              win_col,
    output logic                                       win_row_last
);

    localparam int PIX_BITS = NFMAPS * BITWIDTH;
    localparam int COL_BITS = KER_SIZE * PIX_BITS;
    localparam int WIN_BITS = KER_SIZE * COL_BITS;
    localparam int WB       = $clog2(KER_SIZE + 1);
    localparam int SB       = $clog2(STRIDE + 1);
    localparam int WPR      = windows_per_row(INPUT_X_DIM, KER_SIZE, STRIDE);

    localparam logic [AW-1:0] LAST_COL   = AW'((WPR - 1) * STRIDE);
    localparam logic [AW-1:0] COL_OFS    = AW'(KER_SIZE - 1);
    localparam logic [WB-1:0] FILL_FULL  = WB'(KER_SIZE);
    localparam logic [SB-1:0] STRIDE_MAX = SB'(STRIDE - 1);

    // rd_valid qualifies rd_addr/write_en in the same cycle and rd_data one cycle later;
    // win_valid is a one-cycle pulse with no ready, so the consumer must always accept it.
    logic                rd_valid_q;
    logic [AW-1:0]       rd_addr_q;
    logic [WB-1:0]       w_q, w_d;
    logic [WB-1:0]       fill_q, fill_d, fill_base;
    logic [SB-1:0]       stride_q, stride_d;
    logic                accept, emit;
    logic [COL_BITS-1:0] col_new;
    logic [WIN_BITS-1:0] win_next;
    logic [AW-1:0]       col_start;

    logic                win_valid_q;
    logic [WIN_BITS-1:0] win_data_q;
    logic [AW-1:0]       win_col_q;
    logic                win_row_last_q;

    always_comb begin
        w_d = '0;
        for (int r = 0; r <= KER_SIZE; r++) begin
            if (write_en[r]) begin
                w_d = WB'(r);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            w_q        <= '0;
        end else begin
            rd_valid_q <= rd_valid && !flush;
            rd_addr_q  <= rd_addr;
            w_q        <= w_d;
        end
    end

    // Age-order mux: slot 0 is the oldest row, the write row's slice is never selected.
    always_comb begin
        col_new = '0;
        for (int k = 0; k < KER_SIZE; k++) begin
            for (int r = 0; r <= KER_SIZE; r++) begin
                if (r == row_rotate(int'(w_q), k, KER_SIZE)) begin
                    col_new[k*PIX_BITS +: PIX_BITS] = rd_data[r*PIX_BITS +: PIX_BITS];
                end
            end
        end
    end

    assign accept    = rd_valid_q && !flush;
    assign fill_base = (rd_addr_q == '0) ? '0 : fill_q;
    assign fill_d    = (fill_base == FILL_FULL) ? FILL_FULL : fill_base + WB'(1);
    assign col_start = rd_addr_q - COL_OFS;

    always_comb begin
        stride_d = '0;
        if (fill_d == FILL_FULL && fill_base != FILL_FULL) begin
            stride_d = '0;
        end else if (fill_d == FILL_FULL) begin
            stride_d = (stride_q == STRIDE_MAX) ? '0 : stride_q + SB'(1);
        end
    end

    assign emit = accept && (fill_d == FILL_FULL) && (stride_d == '0);

    window_shift_reg #(
        .KER_SIZE (KER_SIZE),
        .PIX_W    (PIX_BITS),
        .COL_W    (COL_BITS)
    ) u_shift (
        .clk        (clk),
        .rstn       (rstn),
        .clr_i      (flush),
        .shift_i    (accept),
        .col_i      (col_new),
        .win_next_o (win_next)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_q         <= '0;
            stride_q       <= '0;
            win_valid_q    <= 1'b0;
            win_data_q     <= '0;
            win_col_q      <= '0;
            win_row_last_q <= 1'b0;
        end else begin
            if (flush) begin
                fill_q   <= '0;
                stride_q <= '0;
            end else if (accept) begin
                fill_q   <= fill_d;
                stride_q <= stride_d;
            end
            win_valid_q <= emit;
            // Emitted columns are multiples of STRIDE, so the last one is the only match.
            if (emit) begin
                win_data_q     <= win_next;
                win_col_q      <= col_start;
                win_row_last_q <= (col_start == LAST_COL);
            end
        end
    end

    assign win_valid    = win_valid_q;
    assign win_data     = win_data_q;
    assign win_col      = win_col_q;
    assign win_row_last = win_row_last_q;

endmodule

// File: doc/line_window_gen.md
# line_window_gen

Sliding-window generator that sits directly downstream of the line-buffer SRAM controller. Each cycle it takes one column of pixels from the KER_SIZE+1 row SRAMs, and discards the row currently being written. It rotates the remaining KER_SIZE rows into age order and shifts them into a KER_SIZE×KER_SIZE×NFMAPS register window. It emits one window per STRIDE columns to the convolution datapath, without backpressure.

## Interface
- KER_SIZE, 3, kernel height/width
- BITWIDTH, 8, bits per pixel per fmap
- STRIDE, 8, column stride between emitted windows (≥1)
- NFMAPS, 3, input feature maps per pixel
- INPUT_X_DIM, 28, pixels per input row
- AW, 5, column address width
- clk  in  1  clock; single clock domain
- rstn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of window state
- rd_valid  in  1  column read issued this cycle (controller valid && ready)
- rd_addr  in  AW  column address issued this cycle
- write_en  in  KER_SIZE+1  one-hot row being written this cycle
- rd_data  in  (KER_SIZE+1)*NFMAPS*BITWIDTH  SRAM read data; row r in slice r; valid one cycle after rd_valid
- win_valid  out  1  window valid this cycle
- win_data  out  KER_SIZE*KER_SIZE*NFMAPS*BITWIDTH  packed [row][col][fmap][bit]; row 0 is oldest, col 0 is leftmost
- win_col  out  AW  start column of emitted window
- win_row_last  out  1  last window of the current row

## Operation
- Stage 0 (read cycle): register rd_valid, rd_addr and the write_en row index as w_d.
- Stage 1 (data cycle): when rd_valid_d is set, select rows in age order.
  - Top row (row 0) = (w_d+1) mod (KER_SIZE+1).
  - Row k = (w_d+1+k) mod (KER_SIZE+1), for k = 0..KER_SIZE-1.
  - The write row's slice is never used.
- Shift: the column register array shifts left by one. The new KER_SIZE-pixel column enters at col KER_SIZE-1.
- Column fill counter: counts accepted columns and saturates at KER_SIZE. It clears when rd_addr_d==0, which marks the start of a new row.
- Stride counter: clears to 0 on the first column where fill reaches KER_SIZE. It then increments per accepted column and wraps at STRIDE-1.
- Emit condition: fill==KER_SIZE (counting this column) and stride counter==0.
  - win_col = rd_addr_d-(KER_SIZE-1).
  - win_row_last = 1 when win_col+STRIDE > INPUT_X_DIM-KER_SIZE.
- Windows per row: floor((INPUT_X_DIM-KER_SIZE)/STRIDE)+1. Defaults give 4 windows, win_col 0, 8, 16, 24.
- Columns after the last window in a row are shifted but never emitted. A column with rd_addr_d==0 always restarts fill and stride.
- flush: clears fill, the stride counter, rd_valid_d and win_valid on the next edge. An in-flight read is dropped.
- Reset: all outputs 0 (win_valid, win_data, win_col, win_row_last). All counters are 0 and the shift array is 0.

## Timing
- Latency: rd_valid at cycle t, rd_data at t+1, win_valid at t+2 (registered output).
- Throughput: one column per cycle, no bubbles. A gap in rd_valid holds all state, and win_valid is 0 for that cycle.
- win_valid is a single-cycle pulse per window. The win_data, win_col and win_row_last outputs hold their values until the next emit.
- Simultaneous flush and rd_valid: flush wins, and the column is not captured.
- Asynchronous reset mid-row: the next accepted column must be rd_addr==0. Behaviour is undefined otherwise.
- Index arithmetic: the modulo (KER_SIZE+1) index uses a compare-and-subtract, not a divider. All counters are sized with $clog2 and never overflow.

## Structure
- Shared package dfz_window_pkg:
  - pixel width localparams: PIX_W=NFMAPS*BITWIDTH, COL_W=KER_SIZE*PIX_W
  - function row_rotate(w, k)
  - windows-per-row constant function
- Sub-module window_shift_reg holds the KER_SIZE×KER_SIZE register array with shift-enable and clear. The top level holds the counters, the rotate mux and the output register.

## Test plan
- Reset release with defaults: all outputs 0. With no rd_valid, win_valid stays 0 for 100 cycles.
- Defaults, one full row, write_en=0001, rows 1..3 holding pattern row*100+col: windows at win_col 0, 8, 16, 24, each 2 cycles after rd_addr 2, 10, 18, 26. Row 0 of win_data = row 1 data. win_row_last=1 only at col 24.
- write_en rotates through 0010, 0100, 1000 on successive rows: top row = (w+1) mod 4 each time. The write-row slice is filled with 0xFF and never appears in win_data.
- STRIDE=1, INPUT_X_DIM=8, KER_SIZE=3: 6 windows per row, win_col 0..5 on consecutive cycles.
- Random rd_valid gaps (50% duty) with defaults: same windows and win_col sequence as the gap-free run. No win_valid during gaps.
- flush asserted at rd_addr 12, restart at rd_addr 0: no window from the partial row. The next row emits the normal 4 windows.
